// File: rtl/ysyx_24100006_pipe_stage.sv
// ysyx_24100006_pipe_stage: valid/ready pipeline stage with optional skid entry, flush and redirect kill
//   clk, reset (async active-low)
//   in_valid/in_ready/in_data/in_redirect     : upstream handshake and entry
//   out_valid/out_ready/out_data/out_redirect : downstream handshake, driven straight from the head entry
//   flush_i                                   : drop every stored entry and any same-cycle accept
//   occupancy                                 : number of valid entries (head + skid)
module ysyx_24100006_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int SKID = 1,
  parameter int KILL_ON_REDIRECT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_redirect,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_redirect,
  input  logic              flush_i,
  output logic [1:0]        occupancy
);
  localparam bit HAS_S = SKID != 0;
  localparam bit KILL = KILL_ON_REDIRECT != 0;
  logic              h_v_q, h_v_d, h_r_q, h_r_d, s_v_q, s_v_d, s_r_q, s_r_d;
  logic [DATA_W-1:0] h_data_q, h_data_d, s_data_q;
  logic              in_fire, out_fire, kill, drop, h_ld_in, h_ld_s, s_ld, h_we, s_we;
  assign out_valid = h_v_q;
  assign out_data = h_data_q;
  assign out_redirect = h_r_q;
  assign occupancy = {1'b0, h_v_q} + {1'b0, s_v_q};
  // with a skid entry, ready depends only on state so no comb path crosses the stage
  assign in_ready = HAS_S ? !s_v_q : (!h_v_q || out_ready);
  always_comb begin
    in_fire = in_valid && in_ready;
    out_fire = h_v_q && out_ready;
    kill = KILL && out_fire && h_r_q;
    drop = flush_i || kill;
    h_ld_s = HAS_S && out_fire && s_v_q;
    h_ld_in = in_fire && (!h_v_q || (out_fire && !s_v_q));
    s_ld = HAS_S && in_fire && h_v_q && !out_fire;
    h_we = !drop && (h_ld_in || h_ld_s);
    s_we = !drop && s_ld;
    h_data_d = h_ld_s ? s_data_q : in_data;
    h_v_d = drop ? 1'b0 : h_we ? 1'b1 : out_fire ? 1'b0 : h_v_q;
    h_r_d = drop ? 1'b0 : h_ld_s ? s_r_q : h_ld_in ? in_redirect : out_fire ? 1'b0 : h_r_q;
    s_v_d = drop ? 1'b0 : s_ld ? 1'b1 : h_ld_s ? 1'b0 : s_v_q;
    s_r_d = drop ? 1'b0 : s_ld ? in_redirect : h_ld_s ? 1'b0 : s_r_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_v_q <= 1'b0;
      h_r_q <= 1'b0;
      s_v_q <= 1'b0;
      s_r_q <= 1'b0;
      h_data_q <= '0;
      s_data_q <= '0;
    end else begin
      h_v_q <= h_v_d;
      h_r_q <= h_r_d;
      s_v_q <= s_v_d;
      s_r_q <= s_r_d;
      if (h_we) h_data_q <= h_data_d;
      if (s_we) s_data_q <= in_data;
    end
  end
endmodule

// File: tb/tb_ysyx_24100006_pipe_stage.sv
// tb_ysyx_24100006_pipe_stage: directed vectors and scoreboard for the pipe stage (SKID=0/KILL=0 and SKID=1/KILL=1)
module tb_ysyx_24100006_pipe_stage;
  logic clk = 1'b0, reset = 1'b0, iv = 1'b0, red = 1'b0, ordy = 1'b0, fl = 1'b0;
  logic [31:0] id = '0;
  logic ir0, ov0, or0, ir1, ov1, or1;
  logic [31:0] od0, od1;
  logic [1:0] oc0, oc1;
  int nvec = 0, nbad = 0;

  typedef struct packed {
    logic [3:0]  in;
    logic [31:0] d;
    logic [2:0]  ex;
    logic [31:0] ed;
    logic [1:0]  eo;
  } vec_t;

  vec_t t1[24];
  vec_t t0[13];

  always #5 clk = ~clk;

  ysyx_24100006_pipe_stage #(.DATA_W(32), .SKID(0), .KILL_ON_REDIRECT(0)) u0 (
    .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir0), .in_data(id), .in_redirect(red),
    .out_valid(ov0), .out_ready(ordy), .out_data(od0), .out_redirect(or0), .flush_i(fl), .occupancy(oc0));

  ysyx_24100006_pipe_stage #(.DATA_W(32), .SKID(1), .KILL_ON_REDIRECT(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir1), .in_data(id), .in_redirect(red),
    .out_valid(ov1), .out_ready(ordy), .out_data(od1), .out_redirect(or1), .flush_i(fl), .occupancy(oc1));

  // in = {in_valid, in_redirect, out_ready, flush_i}; ex = {out_valid, in_ready, out_redirect}
  function automatic vec_t mk(input logic [3:0] i, input logic [31:0] d, input logic [2:0] e,
                              input logic [31:0] ed, input logic [1:0] eo);
    mk.in = i;
    mk.d = d;
    mk.ex = e;
    mk.ed = ed;
    mk.eo = eo;
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic o, input logic f);
    @(negedge clk);
    iv = v;
    id = d;
    red = r;
    ordy = o;
    fl = f;
    #1;
  endtask

  task automatic chk(input int k, input string nm, input logic e_ov, input logic e_ir, input logic e_r,
                     input logic [31:0] e_d, input logic [1:0] e_oc);
    logic a_ov, a_ir, a_r;
    logic [31:0] a_d;
    logic [1:0] a_oc;
    a_ov = k != 0 ? ov1 : ov0;
    a_ir = k != 0 ? ir1 : ir0;
    a_r = k != 0 ? or1 : or0;
    a_d = k != 0 ? od1 : od0;
    a_oc = k != 0 ? oc1 : oc0;
    nvec++;
    if ({a_ov, a_ir, a_r, a_d, a_oc} !== {e_ov, e_ir, e_r, e_d, e_oc}) begin
      nbad++;
      $display("FAIL %s dut%0d: got v=%b rdy=%b r=%b d=%h occ=%0d, want v=%b rdy=%b r=%b d=%h occ=%0d",
               nm, k, a_ov, a_ir, a_r, a_d, a_oc, e_ov, e_ir, e_r, e_d, e_oc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    iv = 1'b0;
    red = 1'b0;
    ordy = 1'b0;
    fl = 1'b0;
    id = '0;
    #1;
    for (int k = 0; k < 2; k++) chk(k, "reset", 1'b0, 1'b1, 1'b0, 32'h0, 2'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic v, r, o, f, eir, ev, ofire, bad;
    logic [31:0] d;
    logic [32:0] q[$], q0[$], q1[$];
    t1 = '{
      mk(4'b0000, 32'h00, 3'b010, 32'h00, 2'd0),
      mk(4'b1000, 32'h11, 3'b010, 32'h00, 2'd0),
      mk(4'b1000, 32'h22, 3'b110, 32'h11, 2'd1),
      mk(4'b1000, 32'h33, 3'b100, 32'h11, 2'd2),
      mk(4'b1010, 32'h33, 3'b100, 32'h11, 2'd2),
      mk(4'b1010, 32'h33, 3'b110, 32'h22, 2'd1),
      mk(4'b0010, 32'h00, 3'b110, 32'h33, 2'd1),
      mk(4'b0000, 32'h00, 3'b010, 32'h33, 2'd0),
      mk(4'b1100, 32'hA0, 3'b010, 32'h33, 2'd0),
      mk(4'b1000, 32'hA4, 3'b111, 32'hA0, 2'd1),
      mk(4'b1010, 32'hA8, 3'b101, 32'hA0, 2'd2),
      mk(4'b0000, 32'h00, 3'b010, 32'hA0, 2'd0),
      mk(4'b1100, 32'hB0, 3'b010, 32'hA0, 2'd0),
      mk(4'b1010, 32'hB4, 3'b111, 32'hB0, 2'd1),
      mk(4'b0000, 32'h00, 3'b010, 32'hB0, 2'd0),
      mk(4'b1000, 32'hC1, 3'b010, 32'hB0, 2'd0),
      mk(4'b1000, 32'hC2, 3'b110, 32'hC1, 2'd1),
      mk(4'b1011, 32'hC3, 3'b100, 32'hC1, 2'd2),
      mk(4'b0000, 32'h00, 3'b010, 32'hC1, 2'd0),
      mk(4'b1001, 32'hD1, 3'b010, 32'hC1, 2'd0),
      mk(4'b0000, 32'h00, 3'b010, 32'hC1, 2'd0),
      mk(4'b1100, 32'hE0, 3'b010, 32'hC1, 2'd0),
      mk(4'b0001, 32'h00, 3'b111, 32'hE0, 2'd1),
      mk(4'b0000, 32'h00, 3'b010, 32'hE0, 2'd0)
    };
    t0 = '{
      mk(4'b0000, 32'h00, 3'b010, 32'h00, 2'd0),
      mk(4'b1000, 32'h11, 3'b010, 32'h00, 2'd0),
      mk(4'b1000, 32'h22, 3'b100, 32'h11, 2'd1),
      mk(4'b1010, 32'h22, 3'b110, 32'h11, 2'd1),
      mk(4'b1110, 32'hF0, 3'b110, 32'h22, 2'd1),
      mk(4'b1010, 32'hF4, 3'b111, 32'hF0, 2'd1),
      mk(4'b0010, 32'h00, 3'b110, 32'hF4, 2'd1),
      mk(4'b0000, 32'h00, 3'b010, 32'hF4, 2'd0),
      mk(4'b1011, 32'h33, 3'b010, 32'hF4, 2'd0),
      mk(4'b0000, 32'h00, 3'b010, 32'hF4, 2'd0),
      mk(4'b1000, 32'h44, 3'b010, 32'hF4, 2'd0),
      mk(4'b0001, 32'h00, 3'b100, 32'h44, 2'd1),
      mk(4'b0000, 32'h00, 3'b010, 32'h44, 2'd0)
    };
    do_reset();
    for (int i = 0; i < $size(t1); i++) begin
      drive(t1[i].in[3], t1[i].d, t1[i].in[2], t1[i].in[1], t1[i].in[0]);
      chk(1, $sformatf("skid_vec%0d", i), t1[i].ex[2], t1[i].ex[1], t1[i].ex[0], t1[i].ed, t1[i].eo);
    end
    do_reset();
    for (int i = 0; i < $size(t0); i++) begin
      drive(t0[i].in[3], t0[i].d, t0[i].in[2], t0[i].in[1], t0[i].in[0]);
      chk(0, $sformatf("single_vec%0d", i), t0[i].ex[2], t0[i].ex[1], t0[i].ex[0], t0[i].ed, t0[i].eo);
    end
    for (int k = 0; k < 2; k++) begin
      do_reset();
      for (int i = 0; i <= 100; i++) begin
        drive(i < 100, i + 1, 1'b0, 1'b1, 1'b0);
        if (i == 0) chk(k, "stream", 1'b0, 1'b1, 1'b0, 32'h0, 2'd0);
        else chk(k, "stream", 1'b1, 1'b1, 1'b0, i, 2'd1);
      end
    end
    do_reset();
    drive(1'b1, 32'h61, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h62, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h00, 1'b0, 1'b1, 1'b0);
    chk(1, "full_before_rst", 1'b1, 1'b0, 1'b0, 32'h61, 2'd2);
    #2 reset = 1'b0;
    #1 chk(1, "async_rst", 1'b0, 1'b1, 1'b0, 32'h0, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h00, 1'b0, 1'b0, 1'b0);
    chk(1, "post_rst_push", 1'b1, 1'b1, 1'b0, 32'h55, 2'd1);
    do_reset();
    q0 = {};
    q1 = {};
    for (int n = 0; n < 400; n++) begin
      v = $urandom_range(0, 3) != 0;
      d = $urandom;
      r = $urandom_range(0, 7) == 0;
      o = $urandom_range(0, 2) != 0;
      f = $urandom_range(0, 31) == 0;
      drive(v, d, r, o, f);
      for (int k = 0; k < 2; k++) begin
        q = k != 0 ? q1 : q0;
        ev = q.size() != 0;
        eir = k != 0 ? q.size() < 2 : (q.size() == 0 || o);
        bad = (k != 0 ? ov1 : ov0) !== ev || (k != 0 ? ir1 : ir0) !== eir ||
              (k != 0 ? oc1 : oc0) !== 2'(q.size()) ||
              (ev && (k != 0 ? {or1, od1} : {or0, od0}) !== q[0]);
        nvec++;
        if (bad) begin
          nbad++;
          $display("FAIL random dut%0d step%0d: got v=%b rdy=%b occ=%0d r/d=%h, want v=%b rdy=%b occ=%0d r/d=%h",
                   k, n, k != 0 ? ov1 : ov0, k != 0 ? ir1 : ir0, k != 0 ? oc1 : oc0,
                   k != 0 ? {or1, od1} : {or0, od0}, ev, eir, q.size(), ev ? q[0] : 33'h0);
        end
        ofire = o && ev;
        if (f) q.delete();
        else if (k != 0 && ofire && q[0][32]) q.delete();
        else begin
          if (ofire) void'(q.pop_front());
          if (v && eir) q.push_back({r, d});
        end
        if (k != 0) q1 = q;
        else q0 = q;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/ysyx_24100006_pipe_stage.md
YSYX_24100006_PIPE_STAGE -- requirements
Module: ysyx_24100006_pipe_stage

Interface
REQ-001 Parameter DATA_W, default 32, payload width in bits (1..256).
REQ-002 Parameter SKID, default 1; 0 = single-entry stage; 1 = two-entry skid stage with registered in_ready.
REQ-003 Parameter KILL_ON_REDIRECT, default 1; 1 = redirect handshake discards all younger entries.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserted (0) clears state immediately, deasserted synchronously by the system.
REQ-006 in_valid  input  1  upstream entry valid.
REQ-007 in_ready  output  1  stage accepts an entry this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 in_redirect  input  1  entry carries a taken redirect (branch/jump/trap NPC).
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  downstream accepts head entry.
REQ-012 out_data  output  DATA_W  head payload.
REQ-013 out_redirect  output  1  head entry redirect flag.
REQ-014 flush_i  input  1  exception/interrupt flush.
REQ-015 occupancy  output  2  number of valid entries (0..2; max 1 when SKID=0).

Function
REQ-016 in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
REQ-017 Storage SHALL be a head entry H and, when SKID=1, a skid entry S, each {valid, redirect, data}; outputs driven directly from H.
REQ-018 SKID=0: in_ready SHALL equal !H.valid || out_ready (combinational from out_ready).
REQ-019 SKID=1: in_ready SHALL equal !S.valid, a register-only function with no combinational path from out_ready or in_valid.
REQ-020 Normal operation, priority below reset/flush/kill: in_fire with H empty, or with out_fire and S empty, loads H from input.
REQ-021 SKID=1: in_fire with H full and no out_fire loads S; out_fire with S valid moves S into H and empties S.
REQ-022 out_fire with no in_fire and S empty clears H.valid; without out_fire, H and S hold payload and flags unchanged.
REQ-023 Latency: accepted entry SHALL appear on out_* the cycle after in_fire when stage empty; throughput one entry/cycle under continuous out_ready for both SKID values.
REQ-024 Order SHALL be preserved; no entry duplicated or lost except by REQ-025/026.
REQ-025 flush_i=1: H.valid, S.valid, H.redirect, S.redirect cleared next edge; in_fire that cycle discarded; payload registers may hold stale data.
REQ-026 KILL_ON_REDIRECT=1 and out_fire with out_redirect=1: head consumed normally, S and any same-cycle in_fire discarded; stage empty next cycle.
REQ-027 KILL_ON_REDIRECT=0: redirect entries flow like any other entry.
REQ-028 Priority: reset > flush_i > redirect kill > normal.
REQ-029 Payload registers SHALL load only on their write enable.
REQ-030 occupancy SHALL equal H.valid + S.valid, registered-consistent with out_valid and in_ready every cycle.
REQ-031 Protocol: once out_valid=1 and out_ready=0, out_data and out_redirect SHALL stay stable until out_fire, flush or reset.

Reset
REQ-032 While reset=0: out_valid=0, out_redirect=0, out_data=0, occupancy=0, S cleared; in_ready=1.
REQ-033 reset asserted mid-transfer SHALL discard all entries with no downstream out_fire that cycle.

Verification
REQ-034 SKID=1, DATA_W=32, out_ready=0, push 0x11,0x22,0x33 -> 0x11 in H, 0x22 in S, in_ready=0, occupancy=2, 0x33 held upstream; release out_ready -> outputs 0x11,0x22,0x33 in consecutive cycles.
REQ-035 Continuous in_valid and out_ready=1 for 100 entries, both SKID values -> 100 outputs, in order, 1/cycle, latency 1.
REQ-036 Head 0xA0 with out_redirect=1, S=0xA4, in_valid=1 data 0xA8, out_ready=1 -> 0xA0 consumed; next cycle occupancy=0, out_valid=0; 0xA4 and 0xA8 never output.
REQ-037 occupancy=2, flush_i=1 with out_ready=1 and in_valid=1 -> next cycle out_valid=0, out_redirect=0, occupancy=0, in_ready=1.
REQ-038 reset driven 0 asynchronously between edges with occupancy=2 -> out_valid and occupancy 0 before next edge; after release first push 0x55 appears next cycle.
REQ-039 Random in_valid/out_ready/flush_i with scoreboard -> no loss, duplication or reorder outside REQ-025/026; REQ-031 stability holds.
